// File: rtl/lcd_writer.sv
// HD44780 8-bit write-only driver: power-up wait, 4-command init ROM, then host bytes.
// Latency: handshake to lcd_en rise is SETUP_CYC edges; wr_ready is high only in IDLE and drops after acceptance.
module lcd_writer #(
    parameter int unsigned PWRUP_CYC = 750000,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned EN_CYC    = 24,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned CMD_WAIT  = 2000,
    parameter int unsigned CLR_WAIT  = 82000
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       init_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on
);

    typedef enum logic [2:0] {
        PWRUP,
        INIT_LOAD,
        SETUP,
        ENABLE,
        HOLD,
        WAIT,
        IDLE
    } state_t;

    localparam logic [31:0] PWRUP_LD = 32'(PWRUP_CYC - 1);
    localparam logic [31:0] SETUP_LD = 32'(SETUP_CYC - 1);
    localparam logic [31:0] EN_LD    = 32'(EN_CYC - 1);
    localparam logic [31:0] HOLD_LD  = 32'(HOLD_CYC - 1);
    localparam logic [31:0] CMD_LD   = 32'(CMD_WAIT - 1);
    localparam logic [31:0] CLR_LD   = 32'(CLR_WAIT - 1);

    state_t      state;
    state_t      next_state;
    logic [31:0] cnt;
    logic [31:0] cnt_next;
    logic [1:0]  init_idx;
    logic [7:0]  byte_data;
    logic        byte_rs;
    logic [7:0]  rom_byte;
    logic [31:0] wait_ld;
    logic        load_init;
    logic        accept;
    logic        idx_inc;
    logic        done_set;

    always_comb begin
        rom_byte = 8'h38;
        case (init_idx)
            2'd0: rom_byte = 8'h38;
            2'd1: rom_byte = 8'h0C;
            2'd2: rom_byte = 8'h01;
            2'd3: rom_byte = 8'h06;
            default: rom_byte = 8'h38;
        endcase
    end

    // Clear and home are the only slow commands; the same codes as character data are fast.
    always_comb begin
        wait_ld = CMD_LD;
        if (!byte_rs && (byte_data == 8'h01 || byte_data == 8'h02)) begin
            wait_ld = CLR_LD;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt - 32'd1;
        load_init  = 1'b0;
        accept     = 1'b0;
        idx_inc    = 1'b0;
        done_set   = 1'b0;
        case (state)
            PWRUP: begin
                if (cnt == 32'd0) begin
                    next_state = INIT_LOAD;
                end
            end
            INIT_LOAD: begin
                load_init  = 1'b1;
                next_state = SETUP;
                cnt_next   = SETUP_LD;
            end
            SETUP: begin
                if (cnt == 32'd0) begin
                    next_state = ENABLE;
                    cnt_next   = EN_LD;
                end
            end
            ENABLE: begin
                if (cnt == 32'd0) begin
                    next_state = HOLD;
                    cnt_next   = HOLD_LD;
                end
            end
            HOLD: begin
                if (cnt == 32'd0) begin
                    next_state = WAIT;
                    cnt_next   = wait_ld;
                end
            end
            WAIT: begin
                if (cnt == 32'd0) begin
                    if (init_done) begin
                        next_state = IDLE;
                    end else if (init_idx < 2'd3) begin
                        idx_inc    = 1'b1;
                        next_state = INIT_LOAD;
                    end else begin
                        done_set   = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            IDLE: begin
                cnt_next = cnt;
                if (wr_valid) begin
                    accept     = 1'b1;
                    next_state = SETUP;
                    cnt_next   = SETUP_LD;
                end
            end
            default: begin
                next_state = PWRUP;
                cnt_next   = PWRUP_LD;
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (!reset) begin
            state     <= PWRUP;
            cnt       <= PWRUP_LD;
            init_idx  <= 2'd0;
            init_done <= 1'b0;
            byte_data <= 8'h00;
            byte_rs   <= 1'b0;
            lcd_en    <= 1'b0;
            lcd_on    <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= cnt_next;
            lcd_on <= 1'b1;
            // Strobe registered from the next state so it is high exactly while in ENABLE.
            lcd_en <= (next_state == ENABLE);
            if (idx_inc) begin
                init_idx <= init_idx + 2'd1;
            end
            if (done_set) begin
                init_done <= 1'b1;
            end
            if (load_init) begin
                byte_data <= rom_byte;
                byte_rs   <= 1'b0;
            end else if (accept) begin
                byte_data <= wr_data;
                byte_rs   <= wr_rs;
            end
        end
    end

    assign wr_ready = (state == IDLE);
    assign lcd_data = byte_data;
    assign lcd_rs   = byte_rs;
    assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_writer.sv
// Directed bench for lcd_writer: init sequence, host bytes, busy timing, reset mid-pulse, streaming.
module tb_lcd_writer;

    localparam int P = 10, S = 2, E = 4, H = 2, CW = 8, CLR = 20;
    localparam int NH = 2048;

    logic       clock_in = 1'b0;
    logic       reset = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_on;
    logic [7:0] lcd_data;

    lcd_writer #(
        .PWRUP_CYC(P), .SETUP_CYC(S), .EN_CYC(E),
        .HOLD_CYC(H), .CMD_WAIT(CW), .CLR_WAIT(CLR)
    ) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_rs    (wr_rs),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .init_done(init_done),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .lcd_on   (lcd_on)
    );

    always #5 clock_in = ~clock_in;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   rw_bad = 0;
    int   rise_q[$];
    logic en_prev = 1'b0;
    logic       h_en [NH];
    logic       h_rs [NH];
    logic [7:0] h_dat[NH];
    logic       h_rdy[NH];
    logic       h_done[NH];
    logic       h_on [NH];

    always @(posedge clock_in) cyc <= cyc + 1;

    // Each entry holds the outputs as they stand after edge number cyc.
    always @(negedge clock_in) begin
        if (cyc < NH) begin
            h_en[cyc]   <= lcd_en;
            h_rs[cyc]   <= lcd_rs;
            h_dat[cyc]  <= lcd_data;
            h_rdy[cyc]  <= wr_ready;
            h_done[cyc] <= init_done;
            h_on[cyc]   <= lcd_on;
        end
        if (lcd_en === 1'b1 && !en_prev) rise_q.push_back(cyc);
        en_prev <= (lcd_en === 1'b1);
        if (cyc > 0 && lcd_rw !== 1'b0) rw_bad <= rw_bad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offers garbage while the block is busy, then the real byte once wr_ready is seen.
    task automatic send(input logic rs, input logic [7:0] dat, output int h);
        int ok;
        ok = 0;
        h = 0;
        wr_valid = 1'b1;
        wr_rs    = ~rs;
        wr_data  = ~dat;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock_in);
            if (wr_ready === 1'b1) begin
                wr_rs   = rs;
                wr_data = dat;
                @(posedge clock_in);
                #1;
                h  = cyc;
                ok = 1;
                break;
            end
        end
        if (ok == 0) chk("send_timeout", ok, 1);
    endtask

    logic [7:0] exp_dat[17] = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h41, 8'h01, 8'h01, 8'h20, 8'h5A,
                                8'h38, 8'h0C, 8'h01, 8'h06, 8'h48, 8'h69, 8'h80, 8'h02};
    logic       exp_rs [17] = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0};
    int         exp_w  [17] = '{4, 4, 4, 4, 4, 4, 4, 4, 2, 4, 4, 4, 4, 4, 4, 4, 4};

    int r1, r2, ha, hb1, hb2, hb3, hc, hs0, hs1, hs2, hs3;

    initial begin
        repeat (3) @(posedge clock_in);
        #1;
        chk("rst_en", lcd_en, 0);
        chk("rst_rdy", wr_ready, 0);
        chk("rst_done", init_done, 0);
        chk("rst_out", {lcd_on, lcd_rw, lcd_rs, lcd_data}, 11'h000);
        reset = 1'b1;
        r1 = cyc;

        send(1'b1, 8'h41, ha);
        chk("first_accept", ha - r1, 91);
        send(1'b0, 8'h01, hb1);
        send(1'b1, 8'h01, hb2);
        send(1'b0, 8'h20, hb3);
        chk("gap_after_41", hb1 - ha, 17);
        chk("gap_after_clr", hb2 - hb1, 29);
        chk("gap_after_dat01", hb3 - hb2, 17);

        send(1'b1, 8'h5A, hc);
        chk("gap_after_20", hc - hb3, 17);
        wr_valid = 1'b0;
        repeat (3) @(posedge clock_in);
        #1;
        chk("mid_enable", lcd_en, 1);
        reset = 1'b0;
        @(posedge clock_in);
        #1;
        chk("abort_en", lcd_en, 0);
        chk("abort_rdy", wr_ready, 0);
        chk("abort_done", init_done, 0);
        chk("abort_out", {lcd_on, lcd_rw, lcd_rs, lcd_data}, 11'h000);
        @(posedge clock_in);
        #1;
        reset = 1'b1;
        r2 = cyc;

        send(1'b1, 8'h48, hs0);
        send(1'b1, 8'h69, hs1);
        send(1'b0, 8'h80, hs2);
        send(1'b0, 8'h02, hs3);
        wr_valid = 1'b0;
        chk("reinit_accept", hs0 - r2, 91);
        chk("stream_gap1", hs1 - hs0, 17);
        chk("stream_gap2", hs2 - hs1, 17);
        chk("stream_gap3", hs3 - hs2, 17);
        repeat (40) @(posedge clock_in);
        #1;

        chk("on_after_release", h_on[r1 + 1], 1);
        chk("done_before", h_done[r1 + 89], 0);
        chk("done_rise", h_done[r1 + 90], 1);
        chk("rdy_drop", h_rdy[ha], 0);
        chk("rdy_busy", h_rdy[ha + 15], 0);
        chk("rdy_back", h_rdy[ha + 16], 1);
        chk("clr_rdy_busy", h_rdy[hs3 + 27], 0);
        chk("clr_rdy_back", h_rdy[hs3 + 28], 1);

        chk("pulse_count", rise_q.size(), 17);
        if (rise_q.size() >= 17) begin
            chk("first_rise", rise_q[0] - r1, P + 1 + S);
            chk("init_gap1", rise_q[1] - rise_q[0], 17);
            chk("init_gap2", rise_q[2] - rise_q[1], 17);
            chk("init_gap3", rise_q[3] - rise_q[2], 29);
            chk("host_rise", rise_q[4] - ha, 2);
            chk("reinit_rise", rise_q[9] - r2, P + 1 + S);
            for (int i = 0; i < 17; i++) begin
                int rc, w;
                logic [9:0] ev;
                rc = rise_q[i];
                w  = 0;
                while (rc + w < NH && h_en[rc + w] === 1'b1) w++;
                ev = {1'b0, exp_rs[i], exp_dat[i]};
                chk($sformatf("p%0d_width", i), w, exp_w[i]);
                chk($sformatf("p%0d_setup2", i), {h_en[rc - 2], h_rs[rc - 2], h_dat[rc - 2]}, ev);
                chk($sformatf("p%0d_setup1", i), {h_en[rc - 1], h_rs[rc - 1], h_dat[rc - 1]}, ev);
                chk($sformatf("p%0d_mid", i), {h_rs[rc + w - 1], h_dat[rc + w - 1]}, ev[8:0]);
                if (exp_w[i] == E) begin
                    chk($sformatf("p%0d_hold1", i), {h_en[rc + w], h_rs[rc + w], h_dat[rc + w]}, ev);
                    chk($sformatf("p%0d_hold2", i),
                        {h_en[rc + w + 1], h_rs[rc + w + 1], h_dat[rc + w + 1]}, ev);
                end
            end
        end
        chk("rw_zero", rw_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/lcd_writer.md
LCD_WRITER -- requirements
Module: lcd_writer

Interface
REQ-001 Parameter PWRUP_CYC, default 750000: power-up wait before the first init command (15 ms at 50 MHz).
REQ-002 Parameter SETUP_CYC, default 2: cycles lcd_rs/lcd_data are stable with lcd_en low before the enable pulse.
REQ-003 Parameter EN_CYC, default 24: lcd_en high width in cycles.
REQ-004 Parameter HOLD_CYC, default 2: cycles lcd_rs/lcd_data are held after lcd_en falls.
REQ-005 Parameter CMD_WAIT, default 2000: post-write busy time for ordinary commands and data (40 us).
REQ-006 Parameter CLR_WAIT, default 82000: post-write busy time for clear/home commands 0x01/0x02 (1.64 ms).
REQ-007 clock_in  input  1  system clock; all logic is on the rising edge.
REQ-008 reset  input  1  synchronous, active-low reset; 0 at a rising edge resets the block.
REQ-009 wr_valid  input  1  the host offers a byte.
REQ-010 wr_rs  input  1  register select for the offered byte: 0 = command, 1 = character data.
REQ-011 wr_data  input  8  byte offered to the display.
REQ-012 wr_ready  output  1  high only in IDLE; the transfer occurs when wr_valid and wr_ready are both high on a rising edge.
REQ-013 init_done  output  1  high after the init sequence completes, and stays high until reset.
REQ-014 lcd_data  output  8  HD44780 DB7..DB0.
REQ-015 lcd_rs  output  1  HD44780 RS.
REQ-016 lcd_rw  output  1  HD44780 R/W; tied to 0 (write only).
REQ-017 lcd_en  output  1  HD44780 E strobe.
REQ-018 lcd_on  output  1  panel power/backlight enable; 1 whenever not in reset.

Function
REQ-019 The state machine SHALL have these states: PWRUP, INIT_LOAD, SETUP, ENABLE, HOLD, WAIT, IDLE.
REQ-020 PWRUP SHALL count PWRUP_CYC cycles, then go to INIT_LOAD.
REQ-021 INIT_LOAD SHALL latch ROM entry init_idx into the byte register with rs=0, then go to SETUP.
- ROM order: 0x38, 0x0C, 0x01, 0x06.
REQ-022 SETUP SHALL last SETUP_CYC cycles (lcd_en=0), then go to ENABLE.
REQ-023 ENABLE SHALL last EN_CYC cycles (lcd_en=1), then go to HOLD.
REQ-024 HOLD SHALL last HOLD_CYC cycles (lcd_en=0), then go to WAIT.
REQ-025 WAIT SHALL last CLR_WAIT cycles if the latched byte has rs=0 and data 0x01 or 0x02, otherwise CMD_WAIT cycles.
REQ-026 WAIT exit during init SHALL increment init_idx and go to INIT_LOAD if init_idx<3; otherwise it SHALL set init_done and go to IDLE.
REQ-027 WAIT exit after init SHALL go to IDLE.
REQ-028 An accepted host byte SHALL be latched (wr_rs, wr_data) on the handshake edge, with IDLE->SETUP on that same edge.
REQ-029 lcd_data/lcd_rs SHALL reflect the latched byte from SETUP through HOLD inclusive and SHALL NOT change mid-transfer.
REQ-030 lcd_en SHALL be registered and glitch-free, exactly one pulse per byte.
REQ-031 Delay counters SHALL be 32-bit, loaded with (N-1) on state entry, decremented to 0, with the exit on 0; a parameter value of 1 yields exactly one cycle.
REQ-032 Host wr_valid before init_done SHALL be ignored: wr_ready=0 and nothing is latched.
REQ-033 wr_ready SHALL drop on the cycle after acceptance and return only on IDLE re-entry.
- Back-to-back transfers: minimum spacing SETUP_CYC+EN_CYC+HOLD_CYC+wait+1 cycles.
REQ-034 Host inputs changing while wr_ready=0 SHALL have no effect.

Reset
REQ-035 While reset=0 at a rising edge, the block SHALL be in PWRUP with its counter reloaded and init_idx=0.
- Outputs during reset: init_done=0, wr_ready=0, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, lcd_on=0.
REQ-036 Reset asserted mid-transfer (including ENABLE) SHALL force lcd_en=0 on the next edge, abort the transfer, and restart the full init sequence after release.
REQ-037 After release, the first lcd_en rise SHALL occur exactly PWRUP_CYC+1+SETUP_CYC cycles later.

Verification
(Parameters for all scenarios: PWRUP=10, SETUP=2, EN=4, HOLD=2, CMD_WAIT=8, CLR_WAIT=20.)
REQ-038 Release reset -> four lcd_en pulses with data 0x38, 0x0C, 0x01, 0x06, rs=0.
- Gap after 0x01 is 20 cycles; init_done rises after the last wait.
REQ-039 After init, wr_valid=1, wr_rs=1, wr_data=0x41 -> accepted in one cycle, lcd_rs=1, lcd_data=0x41.
- lcd_en high for exactly 4 cycles, with data stable 2 cycles before and after; wr_ready returns 8 cycles after HOLD.
REQ-040 Host sends command 0x01 -> CLR_WAIT (20) busy period.
- Host then sends data 0x01 with rs=1 -> CMD_WAIT (8).
REQ-041 wr_valid held high during init -> no acceptance and no extra lcd_en pulses.
- The first host byte is transferred only after init_done=1.
REQ-042 Assert reset during the ENABLE phase of a host byte -> lcd_en=0 on the next edge and outputs at reset values.
- After release, the init sequence repeats from 0x38.
REQ-043 Hold wr_valid high continuously with changing data -> each byte transferred exactly once per handshake.
- No byte duplicated or dropped; lcd_rw=0 throughout.
